// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg
//   Shared definitions for the Horner polynomial evaluator:
//   - state_t    : evaluator FSM states (IDLE, CALC, DONE)
//   - addr_width : width of the coefficient index for a file of 'depth' words
package poly_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Same value as clog2(depth), but never less than 1 so that a
    // two-word file (DEGREE=1) still gets a real address bit.
    function automatic int addr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/poly_eval_horner_mul_add.sv
// mul_add
//   Combinational Horner step: result = acc * x + c, reduced to WORD_LENGTH.
//   The exact result is formed at full width, so overflow is detected exactly.
//   Optional feature macro: POLY_SATURATE_EN
//     defined   - an overflowing step clamps to 2^WORD_LENGTH-1
//     undefined - an overflowing step keeps the low WORD_LENGTH bits
// Ports:
//   acc      in  WORD_LENGTH  running accumulator
//   x        in  WORD_LENGTH  operand x
//   c        in  WORD_LENGTH  coefficient added in this step
//   result   out WORD_LENGTH  reduced step result
//   overflow out 1            exact result does not fit in WORD_LENGTH bits
module mul_add #(
    parameter int WORD_LENGTH = 8
) (
    input  logic [WORD_LENGTH-1:0] acc,
    input  logic [WORD_LENGTH-1:0] x,
    input  logic [WORD_LENGTH-1:0] c,
    output logic [WORD_LENGTH-1:0] result,
    output logic                   overflow
);

    logic [2*WORD_LENGTH-1:0] product;
    logic [2*WORD_LENGTH:0]   sum;

    always_comb begin
        product  = acc * x;
        // One extra bit keeps the carry of product + c.
        sum      = {1'b0, product} + {{(WORD_LENGTH + 1){1'b0}}, c};
        overflow = |sum[2*WORD_LENGTH:WORD_LENGTH];
`ifdef POLY_SATURATE_EN
        result   = overflow ? {WORD_LENGTH{1'b1}} : sum[WORD_LENGTH-1:0];
`else
        result   = sum[WORD_LENGTH-1:0];
`endif
    end

endmodule

// File: rtl/poly_eval_horner.sv
// poly_eval_horner
//   Evaluates y = c0 + c1*x + ... + cN*x^N with Horner's method on one shared
//   multiply-add step. The FSM sequences it, and the coefficients sit in a
//   small register file that can be written while idle.
//   Optional feature macro: POLY_SATURATE_EN (saturate instead of wrap, see mul_add).
// Ports:
//   clk        in  1            clock, rising edge
//   reset      in  1            synchronous active-low reset
//   start      in  1            request an evaluation (accepted only in IDLE)
//   x_input    in  WORD_LENGTH  operand x, captured when start is accepted
//   coef_we    in  1            coefficient write strobe
//   coef_addr  in  AW           coefficient index
//   coef_data  in  WORD_LENGTH  coefficient value
//   busy       out 1            evaluation in progress
//   done       out 1            one-cycle pulse when y_output/error update
//   error      out 1            overflow seen during last completed evaluation
//   y_output   out WORD_LENGTH  result of last completed evaluation
//
// state | meaning
// IDLE  | waiting for start; coefficient writes allowed
// CALC  | one Horner step per cycle, DEGREE cycles in total
// DONE  | publish acc/err_acc to y_output/error and pulse done
module poly_eval_horner
    import poly_eval_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int DEGREE      = 2,
    localparam int AW         = addr_width(DEGREE + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] x_input,
    input  logic                   coef_we,
    input  logic [AW-1:0]          coef_addr,
    input  logic [WORD_LENGTH-1:0] coef_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WORD_LENGTH-1:0] y_output
);

    state_t                 state;
    state_t                 state_next;

    logic [WORD_LENGTH-1:0] coef [DEGREE+1];
    logic [WORD_LENGTH-1:0] acc;
    logic [WORD_LENGTH-1:0] x_reg;
    logic [AW-1:0]          idx;
    logic                   err_acc;

    logic [WORD_LENGTH-1:0] step_result;
    logic                   step_overflow;
    logic                   accept_start;
    logic                   coef_wr_ok;

    mul_add #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_mul_add (
        .acc      (acc),
        .x        (x_reg),
        .c        (coef[idx]),
        .result   (step_result),
        .overflow (step_overflow)
    );

    // start wins over a same-cycle coefficient write; out-of-range
    // addresses are dropped.
    assign accept_start = (state == IDLE) && start;
    assign coef_wr_ok   = (state == IDLE) && !start && coef_we
                          && (int'(coef_addr) <= DEGREE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (idx == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= DEGREE; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr_ok) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            x_reg    <= '0;
            idx      <= '0;
            err_acc  <= 1'b0;
            y_output <= '0;
            error    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        x_reg   <= x_input;
                        acc     <= coef[DEGREE];
                        idx     <= AW'(DEGREE - 1);
                        err_acc <= 1'b0;
                    end
                end
                CALC: begin
                    acc     <= step_result;
                    err_acc <= err_acc | step_overflow;
                    idx     <= idx - 1'b1;
                end
                DONE: begin
                    y_output <= acc;
                    error    <= err_acc;
                    done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_horner.sv
// tb_poly_eval_horner
//   Directed bench for poly_eval_horner (WORD_LENGTH=8, DEGREE=2).
//   Expected values are hand-computed from c0=4, c1=5, c2=3.
module tb_poly_eval_horner;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] x_input;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] y_output;

    int checks;
    int errors;
    int cyc;
    int bcnt;
    int done_seen;

    poly_eval_horner #(
        .WORD_LENGTH (8),
        .DEGREE      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_input   (x_input),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .y_output  (y_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [7:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    // Pulses start for one edge, then counts cycles until done (bounded).
    task automatic run_eval(input logic [7:0] xv, output int c, output int b);
        start   = 1'b1;
        x_input = xv;
        tick();
        start = 1'b0;
        c = 0;
        b = 0;
        while (!done && c < 20) begin
            if (busy) b++;
            tick();
            c++;
        end
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 20) begin
            tick();
            c++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        x_input   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y_output), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        reset = 1'b1;
        tick();

        write_coef(2'd0, 8'd4);
        write_coef(2'd1, 8'd5);
        write_coef(2'd2, 8'd3);

        // 1: x=2 -> 3*4 + 5*2 + 4 = 26
        run_eval(8'd2, cyc, bcnt);
        check("t1_latency", 32'(cyc), 32'd3);
        check("t1_busy_cycles", 32'(bcnt), 32'd3);
        check("t1_y", 32'(y_output), 32'd26);
        check("t1_err", 32'(error), 32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);

        // 3: x=0 -> 4, then start in the done cycle with x=1 -> 12
        run_eval(8'd0, cyc, bcnt);
        check("t3_y0", 32'(y_output), 32'd4);
        run_eval(8'd1, cyc, bcnt);
        check("t3_b2b_latency", 32'(cyc), 32'd3);
        check("t3_b2b_busy", 32'(bcnt), 32'd3);
        check("t3_y1", 32'(y_output), 32'd12);

        // 4: coefficient write and start pulses while busy are ignored
        tick();
        start   = 1'b1;
        x_input = 8'd2;
        tick();
        x_input   = 8'd9;
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'd9;
        tick();
        check("t4_y_hold", 32'(y_output), 32'd12);
        tick();
        start   = 1'b0;
        coef_we = 1'b0;
        wait_done(cyc);
        check("t4_y", 32'(y_output), 32'd26);
        check("t4_no_restart", 32'(cyc), 32'd1);
        tick();
        check("t4_idle", 32'(busy), 32'd0);
        run_eval(8'd2, cyc, bcnt);
        check("t4_y_next", 32'(y_output), 32'd26);

        // 6: write together with start is dropped; addr 3 is ignored
        tick();
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'd100;
        run_eval(8'd2, cyc, bcnt);
        coef_we = 1'b0;
        check("t6_start_prio", 32'(y_output), 32'd26);
        write_coef(2'd3, 8'd50);
        run_eval(8'd2, cyc, bcnt);
        check("t6_addr3", 32'(y_output), 32'd26);

        // 2: x=10 -> 35, then 354 overflows
        run_eval(8'd10, cyc, bcnt);
`ifdef POLY_SATURATE_EN
        check("t2_y_sat", 32'(y_output), 32'd255);
`else
        check("t2_y_wrap", 32'(y_output), 32'd98);
`endif
        check("t2_err", 32'(error), 32'd1);
        run_eval(8'd1, cyc, bcnt);
        check("t2_err_clears", 32'(error), 32'd0);
        run_eval(8'd10, cyc, bcnt);
        check("t2_err_again", 32'(error), 32'd1);

        // 5: reset during CALC aborts and clears everything
        tick();
        start   = 1'b1;
        x_input = 8'd2;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_y", 32'(y_output), 32'd0);
        check("t5_err", 32'(error), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        run_eval(8'd7, cyc, bcnt);
        check("t5_latency", 32'(cyc), 32'd3);
        check("t5_y_zero_coef", 32'(y_output), 32'd0);
        check("t5_err_zero_coef", 32'(error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
